inst_cache: RTL

- Direct-mapped, read-only instruction cache that answers Fetch stage lookups.
- Fetch drives a PC; this block returns `hit` and `instruction` in the same cycle.
- On a miss, a refill FSM reads the whole line from backing instruction memory over a req/ack handshake, then serves the hit.
- Sits between the Fetch stage and the instruction memory.

---
 rtl/inst_cache_pkg.sv | 24 ++
 rtl/inst_cache_if.sv | 32 +++
 rtl/inst_cache_refill_fsm.sv | 80 ++++++++
 rtl/inst_cache.sv | 128 ++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache: refill FSM state encoding,
// default geometry and a constant-foldable log2 helper.
package cache_pkg;

   localparam int DEF_LINES          = 32'sd16;
   localparam int DEF_WORDS_PER_LINE = 32'sd4;
   localparam int DEF_ADDR_W         = 32'sd32;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REFILL = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 32'sd0;
      for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
         r = r + 32'sd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side lookup and instruction-memory refill bundle.
// Build option INST_CACHE_STATS_EN adds the hit/miss counters.
interface inst_cache_if #(parameter int ADDR_W = cache_pkg::DEF_ADDR_W);
   logic [ADDR_W-1:0] pc;
   logic              pc_valid;
   logic              hit;
   logic [31:0]       instruction;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [31:0]       mem_rdata;
`ifdef INST_CACHE_STATS_EN
   logic [31:0]       hit_count;
   logic [31:0]       miss_count;
`endif

   modport slave (
      input  pc, pc_valid, mem_ack, mem_rdata,
`ifdef INST_CACHE_STATS_EN
      output hit_count, miss_count,
`endif
      output hit, instruction, mem_req, mem_addr
   );

   modport master (
      output pc, pc_valid, mem_ack, mem_rdata,
`ifdef INST_CACHE_STATS_EN
      input  hit_count, miss_count,
`endif
      input  hit, instruction, mem_req, mem_addr
   );
endinterface

// File: rtl/inst_cache_refill_fsm.sv
// Line refill sequencer: walks one cache line out of instruction memory
// over req/ack, then raises a one-cycle commit before returning to idle.
module inst_cache_refill_fsm
   import cache_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
   localparam int OFF           = clog2(WORDS_PER_LINE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              fill_we,
   output logic [OFF-1:0]    fill_beat,
   output logic              commit,
   output logic              idle
);

   state_t          state_r;
   logic [OFF-1:0]  beat_r;
   logic            req_r;
   logic [ADDR_W-1:0] addr_r;

   // State, beat counter and memory request registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
         beat_r  <= '0;
         req_r   <= 1'b0;
         addr_r  <= '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  state_r <= S_REFILL;
                  beat_r  <= '0;
                  req_r   <= 1'b1;
                  addr_r  <= start_addr;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_REFILL: begin
               if (req_r && mem_ack) begin
                  beat_r <= beat_r + OFF'(1);
                  addr_r <= addr_r + ADDR_W'(4);
                  // the counter wraps to zero on the last beat by construction
                  if (beat_r == OFF'(WORDS_PER_LINE - 1)) begin
                     req_r   <= 1'b0;
                     state_r <= S_COMMIT;
                  end else begin
                     state_r <= S_REFILL;
                  end
               end else begin
                  state_r <= S_REFILL;
               end
            end
            S_COMMIT: begin
               state_r <= S_IDLE;
            end
            default: begin
               state_r <= S_IDLE;
               req_r   <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req   = req_r;
   assign mem_addr  = addr_r;
   assign fill_we   = (state_r == S_REFILL) & req_r & mem_ack;
   assign fill_beat = beat_r;
   assign commit    = (state_r == S_COMMIT);
   assign idle      = (state_r == S_IDLE);

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with same-cycle lookup.
// Build option INST_CACHE_STATS_EN adds saturating hit/miss counters.
module inst_cache
   import cache_pkg::*;
#(
   parameter int LINES          = DEF_LINES,
   parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
   parameter int ADDR_W         = DEF_ADDR_W
) (
   input  logic         clk,
   input  logic         rst,
   inst_cache_if.slave  bus
);

   localparam int OFF   = clog2(WORDS_PER_LINE);
   localparam int IDX   = clog2(LINES);
   localparam int TAG_W = ADDR_W - OFF - IDX - 2;

   logic [OFF-1:0]    off_s;
   logic [IDX-1:0]    idx_s;
   logic [TAG_W-1:0]  tag_s;
   logic [ADDR_W-1:0] line_base_s;
   logic              hit_s;
   logic [31:0]       instr_s;
   logic              miss_s;
   logic              idle_s;
   logic              fill_we_s;
   logic [OFF-1:0]    fill_beat_s;
   logic              commit_s;
   logic              unused_s;

   logic [LINES-1:0]  valid_r;
   logic [TAG_W-1:0]  tag_r  [LINES];
   logic [31:0]       data_r [LINES][WORDS_PER_LINE];
   logic [TAG_W-1:0]  miss_tag_r;
   logic [IDX-1:0]    miss_index_r;

   assign off_s       = bus.pc[OFF+1:2];
   assign idx_s       = bus.pc[OFF+IDX+1:OFF+2];
   assign tag_s       = bus.pc[ADDR_W-1:OFF+IDX+2];
   assign line_base_s = {bus.pc[ADDR_W-1:OFF+2], {(OFF+2){1'b0}}};
   assign unused_s    = ^bus.pc[1:0];

   // Same-cycle lookup; a NOP is presented whenever there is no hit
   always_comb begin
      hit_s   = 1'b0;
      instr_s = 32'h0000_0000;
      if (bus.pc_valid && idle_s && valid_r[idx_s] && (tag_r[idx_s] == tag_s)) begin
         hit_s   = 1'b1;
         instr_s = data_r[idx_s][off_s];
      end else begin
         hit_s   = 1'b0;
         instr_s = 32'h0000_0000;
      end
   end

   assign miss_s          = bus.pc_valid & idle_s & ~hit_s;
   assign bus.hit         = hit_s;
   assign bus.instruction = instr_s;

   inst_cache_refill_fsm #(
      .ADDR_W         (ADDR_W),
      .WORDS_PER_LINE (WORDS_PER_LINE)
   ) u_refill (
      .clk        (clk),
      .rst        (rst),
      .start      (miss_s),
      .start_addr (line_base_s),
      .mem_ack    (bus.mem_ack),
      .mem_req    (bus.mem_req),
      .mem_addr   (bus.mem_addr),
      .fill_we    (fill_we_s),
      .fill_beat  (fill_beat_s),
      .commit     (commit_s),
      .idle       (idle_s)
   );

   // Valid bits and the latched miss line; the victim is invalidated at miss time
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r      <= '0;
         miss_tag_r   <= '0;
         miss_index_r <= '0;
      end else if (miss_s) begin
         valid_r[idx_s] <= 1'b0;
         miss_tag_r     <= tag_s;
         miss_index_r   <= idx_s;
      end else if (commit_s) begin
         valid_r[miss_index_r] <= 1'b1;
      end else begin
         valid_r <= valid_r;
      end
   end

   // Tag and data storage, guarded by the valid bits so no reset is needed
   always_ff @(posedge clk) begin
      if (fill_we_s) begin
         data_r[miss_index_r][fill_beat_s] <= bus.mem_rdata;
      end
      if (commit_s) begin
         tag_r[miss_index_r] <= miss_tag_r;
      end
   end

`ifdef INST_CACHE_STATS_EN
   logic [31:0] hit_count_r;
   logic [31:0] miss_count_r;

   // Saturating lookup statistics
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count_r  <= 32'h0000_0000;
         miss_count_r <= 32'h0000_0000;
      end else begin
         if (hit_s && (hit_count_r != 32'hFFFF_FFFF)) begin
            hit_count_r <= hit_count_r + 32'h0000_0001;
         end
         if (miss_s && (miss_count_r != 32'hFFFF_FFFF)) begin
            miss_count_r <= miss_count_r + 32'h0000_0001;
         end
      end
   end

   assign bus.hit_count  = hit_count_r;
   assign bus.miss_count = miss_count_r;
`endif

endmodule
